// File: rtl/mult_booth_r4.sv
// Sequential radix-4 (modified Booth) multiplier with valid/ready handshakes,
// signed/unsigned operands, synchronous abort and a scaled, truncated product.
module mult_booth_r4 #(
    parameter int M_SIZE = 8,
    parameter int Q_SIZE = 8,
    parameter int P_SIZE = 16,
    parameter int SHIFT  = 0
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [M_SIZE-1:0] M,
    input  logic [Q_SIZE-1:0] Q,
    input  logic              signed_mode,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [P_SIZE-1:0] P,
    output logic              busy
);
    localparam int QE  = 2 * ((Q_SIZE + 2) / 2);
    localparam int N   = QE / 2;
    // One guard bit beyond M+2 so that A +/- 2M can never wrap before the shift.
    localparam int AW  = M_SIZE + 3;
    localparam int PFW = M_SIZE + Q_SIZE;
    localparam int XW  = PFW + P_SIZE;
    localparam int CW  = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   m_reg;
    logic [AW-1:0]   a_reg;
    logic [QE-1:0]   q_reg;
    logic            q_m1;
    logic            smode;
    logic [CW-1:0]   cnt;

    logic [AW-1:0]   m_ext;
    logic [QE-1:0]   q_ext;
    logic [AW-1:0]   pp;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   a_nxt;
    logic [QE-1:0]   q_nxt;
    logic [AW+QE-1:0] prod_full;
    logic [PFW-1:0]  pf;
    logic [XW-1:0]   pf_ext;
    logic [XW-1:0]   scaled;
    logic [P_SIZE-1:0] p_nxt;
    logic            unused_bits;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);

    assign m_ext = {{3{signed_mode & M[M_SIZE-1]}}, M};
    assign q_ext = {{(QE-Q_SIZE){signed_mode & Q[Q_SIZE-1]}}, Q};

    always_comb begin
        pp = '0;
        case ({q_reg[1:0], q_m1})
            3'b001, 3'b010: pp = m_reg;
            3'b011:         pp = m_reg << 1;
            3'b100:         pp = -(m_reg << 1);
            3'b101, 3'b110: pp = -m_reg;
            default:        pp = '0;
        endcase
    end

    assign sum   = a_reg + pp;
    assign a_nxt = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign q_nxt = {sum[1:0], q_reg[QE-1:2]};

    // Product as it will stand after this step; only latched on the final one.
    assign prod_full = {a_nxt, q_nxt};
    assign pf        = prod_full[PFW-1:0];
    assign pf_ext    = {{P_SIZE{smode & pf[PFW-1]}}, pf};
    assign scaled    = pf_ext >> SHIFT;
    assign p_nxt     = scaled[P_SIZE-1:0];

    assign unused_bits = ^{prod_full[AW+QE-1:PFW], scaled[XW-1:P_SIZE]};

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            m_reg     <= '0;
            a_reg     <= '0;
            q_reg     <= '0;
            q_m1      <= 1'b0;
            smode     <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            P         <= '0;
        end else if (abort) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (in_valid && in_ready) begin
            state     <= RUN;
            m_reg     <= m_ext;
            q_reg     <= q_ext;
            a_reg     <= '0;
            q_m1      <= 1'b0;
            smode     <= signed_mode;
            cnt       <= CW'(N);
            out_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    q_m1  <= q_reg[1];
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        P         <= p_nxt;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
